// File: rtl/oram_flat_backend_pkg.sv
// oram_flat_backend_pkg: shared command encodings, state enum and chunk math
package oram_flat_backend_pkg;
  localparam int BECMDWidth = 2;
  localparam logic [BECMDWidth-1:0] BECMD_Update  = 2'd0;
  localparam logic [BECMDWidth-1:0] BECMD_Append  = 2'd1;
  localparam logic [BECMDWidth-1:0] BECMD_Read    = 2'd2;
  localparam logic [BECMDWidth-1:0] BECMD_ReadRmv = 2'd3;
  typedef enum logic [1:0] {IDLE, STORE, LOAD} beState_t;
  function automatic int blkChunks(int blockBits, int chunkBits);
    return blockBits / chunkBits;
  endfunction
endpackage

// File: rtl/oram_flat_backend_if.sv
// oram_flat_backend_if: frontend-to-backend command, store and load channels
interface oram_flat_backend_if
  import oram_flat_backend_pkg::*;
#(
  parameter int ORAMU = 32,
  parameter int ORAML = 10,
  parameter int FEDWidth = 64
);
  logic                  CmdInReady;
  logic                  CmdInValid;
  logic [BECMDWidth-1:0] CmdIn;
  logic [ORAMU-1:0]      AddrIn;
  logic [ORAML-1:0]      OldLeafIn;
  logic [ORAML-1:0]      NewLeafIn;
  logic                  StoreDataReady;
  logic                  StoreDataValid;
  logic [FEDWidth-1:0]   StoreData;
  logic                  LoadDataReady;
  logic                  LoadDataValid;
  logic [FEDWidth-1:0]   LoadData;
  modport master (
    input  CmdInReady, StoreDataReady, LoadDataValid, LoadData,
    output CmdInValid, CmdIn, AddrIn, OldLeafIn, NewLeafIn, StoreDataValid, StoreData, LoadDataReady
  );
  modport slave (
    output CmdInReady, StoreDataReady, LoadDataValid, LoadData,
    input  CmdInValid, CmdIn, AddrIn, OldLeafIn, NewLeafIn, StoreDataValid, StoreData, LoadDataReady
  );
endinterface

// File: rtl/oram_flat_backend_outq.sv
// oram_flat_backend_outq: 2-entry output FIFO with registered head, absorbs RAM read latency
module oram_flat_backend_outq #(
  parameter int Width = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  input  logic [Width-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [Width-1:0] OutData,
  output logic [1:0]       Level
);
  logic [Width-1:0] head, tail;
  logic [1:0] count;
  logic pop;
  // Head is the output register; tail only fills when head is occupied and not draining
  always_comb begin
    pop = (count != 2'd0) && OutReady;
    OutValid = count != 2'd0;
    OutData = head;
    Level = count;
  end
  // Occupancy count; the producer never pushes into a full queue without a pop
  always_ff @(posedge Clock) begin
    if (!Reset) count <= 2'd0;
    else count <= count + {1'b0, InValid} - {1'b0, pop};
  end
  // Entry shuffling: push lands in head when it frees up, otherwise in tail
  always_ff @(posedge Clock) begin
    if (InValid && (count == 2'd0 || (count == 2'd1 && pop))) head <= InData;
    else if (pop && count == 2'd2) head <= tail;
    if (InValid && (count == 2'd2 || (count == 2'd1 && !pop))) tail <= InData;
  end
endmodule

// File: rtl/oram_flat_backend.sv
// oram_flat_backend: flat block store standing in for the Path ORAM backend
module oram_flat_backend
  import oram_flat_backend_pkg::*;
#(
  parameter int ORAMU = 32,
  parameter int ORAML = 10,
  parameter int ORAMB = 512,
  parameter int FEDWidth = 64,
  parameter int NumBlocks = 1024,
  parameter int LeafCheck = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  oram_flat_backend_if.slave Bus,
  output logic        ErrAddrRange,
  output logic        ErrLeafMismatch,
  output logic        ErrAppendValid,
  output logic [31:0] AccessCount
);
  localparam int BlkChunks = blkChunks(ORAMB, FEDWidth);
  localparam int IdxW = $clog2(NumBlocks);
  localparam int ChkW = $clog2(BlkChunks);
  beState_t state, nextState;
  logic [IdxW-1:0] idx, inIdx;
  logic [BECMDWidth-1:0] cmdReg;
  logic [ChkW:0] rdCnt;
  logic [ChkW-1:0] wrCnt, outCnt;
  logic inFlight, loadZero, chkPending;
  logic [ORAML-1:0] oldLeafReg, leafQ;
  logic [NumBlocks-1:0] blkValid;
  logic [FEDWidth-1:0] dataRam [NumBlocks*BlkChunks];
  logic [ORAML-1:0] leafRam [NumBlocks];
  logic [FEDWidth-1:0] ramQ;
  logic [1:0] level;
  logic accept, storeHs, pop, issue, lastStore, lastLoad;
  // Handshakes, read issue credit and next state; a read is issued only if its data will fit next cycle
  always_comb begin
    inIdx = Bus.AddrIn[IdxW-1:0];
    accept = state == IDLE && Bus.CmdInValid;
    storeHs = state == STORE && Bus.StoreDataValid;
    lastStore = storeHs && wrCnt == ChkW'(BlkChunks - 1);
    pop = Bus.LoadDataValid && Bus.LoadDataReady;
    lastLoad = state == LOAD && pop && outCnt == ChkW'(BlkChunks - 1);
    issue = state == LOAD && rdCnt != (ChkW+1)'(BlkChunks) && (int'(level) + int'(inFlight) - int'(pop)) < 2;
    Bus.CmdInReady = state == IDLE;
    Bus.StoreDataReady = state == STORE;
    nextState = accept ? ((Bus.CmdIn == BECMD_Read || Bus.CmdIn == BECMD_ReadRmv) ? LOAD : STORE)
              : (lastStore || lastLoad) ? IDLE : state;
  end
  // State register
  always_ff @(posedge Clock) begin
    state <= !Reset ? IDLE : nextState;
  end
  // Command capture, counters, valid bits and sticky error flags
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      blkValid <= '0;
      ErrAddrRange <= 1'b0;
      ErrLeafMismatch <= 1'b0;
      ErrAppendValid <= 1'b0;
      AccessCount <= 32'd0;
      idx <= '0;
      cmdReg <= BECMD_Update;
      oldLeafReg <= '0;
      loadZero <= 1'b0;
      wrCnt <= '0;
      rdCnt <= '0;
      outCnt <= '0;
      inFlight <= 1'b0;
      chkPending <= 1'b0;
    end else begin
      inFlight <= issue;
      chkPending <= accept && LeafCheck != 0 && blkValid[inIdx];
      if (chkPending && oldLeafReg != leafQ) ErrLeafMismatch <= 1'b1;
      if (accept) begin
        idx <= inIdx;
        cmdReg <= Bus.CmdIn;
        oldLeafReg <= Bus.OldLeafIn;
        loadZero <= !blkValid[inIdx];
        AccessCount <= AccessCount + 32'd1;
        wrCnt <= '0;
        rdCnt <= '0;
        outCnt <= '0;
        if (Bus.AddrIn >= ORAMU'(NumBlocks)) ErrAddrRange <= 1'b1;
        if (Bus.CmdIn == BECMD_Append && blkValid[inIdx]) ErrAppendValid <= 1'b1;
      end
      if (storeHs) wrCnt <= wrCnt + 1'b1;
      if (lastStore) blkValid[idx] <= 1'b1;
      if (issue) rdCnt <= rdCnt + 1'b1;
      if (pop) outCnt <= outCnt + 1'b1;
      if (lastLoad && cmdReg == BECMD_ReadRmv) blkValid[idx] <= 1'b0;
    end
  end
  // Data RAM: chunk writes during STORE, synchronous chunk reads during LOAD
  always_ff @(posedge Clock) begin
    if (storeHs) dataRam[{idx, wrCnt}] <= Bus.StoreData;
    if (issue) ramQ <= dataRam[{idx, rdCnt[ChkW-1:0]}];
  end
  // Leaf RAM: read old leaf for the consistency check while writing the remapped leaf
  always_ff @(posedge Clock) begin
    if (accept) begin
      leafRam[inIdx] <= Bus.NewLeafIn;
      leafQ <= leafRam[inIdx];
    end
  end
  oram_flat_backend_outq #(.Width(FEDWidth)) outQ (
    .Clock    (Clock),
    .Reset    (Reset),
    .InValid  (inFlight),
    .InData   (loadZero ? '0 : ramQ),
    .OutValid (Bus.LoadDataValid),
    .OutReady (Bus.LoadDataReady),
    .OutData  (Bus.LoadData),
    .Level    (level)
  );
endmodule

// File: tb/tb_oram_flat_backend.sv
// tb_oram_flat_backend: directed scenario bench for the flat ORAM backend
module tb_oram_flat_backend;
  import oram_flat_backend_pkg::*;
  logic Clock = 1'b0;
  logic Reset;
  logic ErrAddrRange, ErrLeafMismatch, ErrAppendValid;
  logic [31:0] AccessCount;
  int nChecks = 0;
  int nFails = 0;
  int waitCyc, firstValid, lastPop, stallBad, busyBad;
  logic doneReady;
  logic [63:0] got [8];
  oram_flat_backend_if bus ();
  oram_flat_backend dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Bus             (bus),
    .ErrAddrRange    (ErrAddrRange),
    .ErrLeafMismatch (ErrLeafMismatch),
    .ErrAppendValid  (ErrAppendValid),
    .AccessCount     (AccessCount)
  );
  always #5 Clock = ~Clock;

  task automatic sendCmd(input logic [1:0] c, input logic [31:0] a, input logic [9:0] ol, input logic [9:0] nl);
    @(negedge Clock);
    bus.StoreDataValid = 1'b0;
    bus.LoadDataReady = 1'b0;
    bus.CmdInValid = 1'b1;
    bus.CmdIn = c;
    bus.AddrIn = a;
    bus.OldLeafIn = ol;
    bus.NewLeafIn = nl;
    waitCyc = 0;
    while (!bus.CmdInReady && waitCyc < 50) begin
      @(negedge Clock);
      waitCyc++;
    end
    if (!bus.CmdInReady) begin
      nChecks++; nFails++;
      $display("FAIL cmd_accept_timeout CmdInReady=%b required 1", bus.CmdInReady);
    end
    @(posedge Clock);
  endtask

  task automatic doStore(input logic [1:0] c, input logic [31:0] a, input logic [9:0] ol, input logic [9:0] nl, input logic [63:0] base);
    sendCmd(c, a, ol, nl);
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      bus.CmdInValid = 1'b0;
      bus.StoreDataValid = 1'b1;
      bus.StoreData = base + 64'(k);
      @(posedge Clock);
    end
  endtask

  task automatic readBlock(input logic [1:0] c, input logic [31:0] a, input logic [9:0] ol, input logic [9:0] nl, input logic [3:0] pat);
    int n, cyc;
    logic rdy, heldV;
    logic [63:0] held;
    sendCmd(c, a, ol, nl);
    n = 0; cyc = 0; firstValid = -1; lastPop = -1; stallBad = 0; busyBad = 0; heldV = 1'b0; held = '0;
    while (n < 8 && cyc < 100) begin
      @(negedge Clock);
      cyc++;
      bus.CmdInValid = 1'b0;
      bus.StoreDataValid = 1'b0;
      rdy = pat[(cyc-1) % 4];
      if (heldV && (!bus.LoadDataValid || bus.LoadData !== held)) stallBad++;
      if (bus.CmdInReady) busyBad++;
      if (bus.LoadDataValid && firstValid < 0) firstValid = cyc - 1;
      bus.LoadDataReady = rdy;
      if (bus.LoadDataValid && rdy) begin
        got[n] = bus.LoadData;
        n++;
        lastPop = cyc - 1;
        heldV = 1'b0;
      end else begin
        heldV = bus.LoadDataValid;
        held = bus.LoadData;
      end
    end
    if (n < 8) begin
      nChecks++; nFails++;
      $display("FAIL load_timeout chunks=%0d required 8", n);
    end
    @(negedge Clock);
    bus.LoadDataReady = 1'b0;
    doneReady = bus.CmdInReady;
  endtask

  task automatic test_reset();
    bus.CmdInValid = 1'b0; bus.CmdIn = '0; bus.AddrIn = '0; bus.OldLeafIn = '0; bus.NewLeafIn = '0;
    bus.StoreDataValid = 1'b0; bus.StoreData = '0; bus.LoadDataReady = 1'b0;
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    nChecks++; if (bus.CmdInReady !== 1'b1) begin nFails++; $display("FAIL reset_cmdready got %b exp 1", bus.CmdInReady); end
    nChecks++; if (bus.StoreDataReady !== 1'b0) begin nFails++; $display("FAIL reset_storeready got %b exp 0", bus.StoreDataReady); end
    nChecks++; if (bus.LoadDataValid !== 1'b0) begin nFails++; $display("FAIL reset_loadvalid got %b exp 0", bus.LoadDataValid); end
    nChecks++; if ({ErrAddrRange, ErrLeafMismatch, ErrAppendValid} !== 3'b000) begin nFails++; $display("FAIL reset_errs got %b exp 000", {ErrAddrRange, ErrLeafMismatch, ErrAppendValid}); end
    nChecks++; if (AccessCount !== 32'd0) begin nFails++; $display("FAIL reset_count got %0d exp 0", AccessCount); end
  endtask

  task automatic test_store_read();
    doStore(BECMD_Update, 32'd5, 10'h0, 10'h11, 64'h10);
    readBlock(BECMD_Read, 32'd5, 10'h11, 10'h11, 4'hF);
    for (int k = 0; k < 8; k++) begin
      nChecks++; if (got[k] !== 64'h10 + 64'(k)) begin nFails++; $display("FAIL store_read_chunk%0d got %h exp %h", k, got[k], 64'h10 + 64'(k)); end
    end
    nChecks++; if (firstValid !== 2) begin nFails++; $display("FAIL first_valid_latency got %0d exp 2", firstValid); end
    nChecks++; if (lastPop - firstValid !== 7) begin nFails++; $display("FAIL burst_span got %0d exp 7", lastPop - firstValid); end
    nChecks++; if (busyBad !== 0) begin nFails++; $display("FAIL cmdready_during_load got %0d exp 0", busyBad); end
    nChecks++; if (doneReady !== 1'b1) begin nFails++; $display("FAIL cmdready_after_load got %b exp 1", doneReady); end
    nChecks++; if (AccessCount !== 32'd2) begin nFails++; $display("FAIL count_after_store_read got %0d exp 2", AccessCount); end
    nChecks++; if (ErrLeafMismatch !== 1'b0) begin nFails++; $display("FAIL leaf_match_no_err got %b exp 0", ErrLeafMismatch); end
  endtask

  task automatic test_unwritten();
    readBlock(BECMD_Read, 32'd9, 10'h0, 10'h3, 4'hF);
    for (int k = 0; k < 8; k++) begin
      nChecks++; if (got[k] !== 64'h0) begin nFails++; $display("FAIL unwritten_chunk%0d got %h exp 0", k, got[k]); end
    end
    nChecks++; if ({ErrAddrRange, ErrLeafMismatch, ErrAppendValid} !== 3'b000) begin nFails++; $display("FAIL unwritten_errs got %b exp 000", {ErrAddrRange, ErrLeafMismatch, ErrAppendValid}); end
    readBlock(BECMD_ReadRmv, 32'd5, 10'h11, 10'h11, 4'hF);
    nChecks++; if (got[7] !== 64'h17) begin nFails++; $display("FAIL readrmv_last got %h exp 17", got[7]); end
    readBlock(BECMD_Read, 32'd5, 10'h11, 10'h11, 4'hF);
    for (int k = 0; k < 8; k++) begin
      nChecks++; if (got[k] !== 64'h0) begin nFails++; $display("FAIL after_rmv_chunk%0d got %h exp 0", k, got[k]); end
    end
  endtask

  task automatic test_backpressure();
    doStore(BECMD_Update, 32'd5, 10'h11, 10'h11, 64'h20);
    readBlock(BECMD_Read, 32'd5, 10'h11, 10'h11, 4'b1001);
    for (int k = 0; k < 8; k++) begin
      nChecks++; if (got[k] !== 64'h20 + 64'(k)) begin nFails++; $display("FAIL bp_chunk%0d got %h exp %h", k, got[k], 64'h20 + 64'(k)); end
    end
    nChecks++; if (stallBad !== 0) begin nFails++; $display("FAIL bp_stall_stable got %0d exp 0", stallBad); end
    nChecks++; if (busyBad !== 0) begin nFails++; $display("FAIL bp_cmdready_busy got %0d exp 0", busyBad); end
    nChecks++; if (doneReady !== 1'b1) begin nFails++; $display("FAIL bp_cmdready_done got %b exp 1", doneReady); end
    nChecks++; if (ErrLeafMismatch !== 1'b0) begin nFails++; $display("FAIL bp_leaf got %b exp 0", ErrLeafMismatch); end
  endtask

  task automatic test_leaf();
    doStore(BECMD_Append, 32'd3, 10'h0, 10'h2A, 64'h30);
    readBlock(BECMD_Read, 32'd3, 10'h2A, 10'h2A, 4'hF);
    nChecks++; if (ErrLeafMismatch !== 1'b0) begin nFails++; $display("FAIL leaf_match got %b exp 0", ErrLeafMismatch); end
    nChecks++; if (ErrAppendValid !== 1'b0) begin nFails++; $display("FAIL append_fresh got %b exp 0", ErrAppendValid); end
    nChecks++; if (got[0] !== 64'h30) begin nFails++; $display("FAIL append_data got %h exp 30", got[0]); end
    readBlock(BECMD_Read, 32'd3, 10'h2B, 10'h2A, 4'hF);
    nChecks++; if (ErrLeafMismatch !== 1'b1) begin nFails++; $display("FAIL leaf_mismatch got %b exp 1", ErrLeafMismatch); end
    readBlock(BECMD_Read, 32'd3, 10'h2A, 10'h2A, 4'hF);
    nChecks++; if (ErrLeafMismatch !== 1'b1) begin nFails++; $display("FAIL leaf_sticky got %b exp 1", ErrLeafMismatch); end
  endtask

  task automatic test_errors();
    doStore(BECMD_Update, 32'd1024, 10'h0, 10'h0, 64'h40);
    @(negedge Clock);
    nChecks++; if (ErrAddrRange !== 1'b1) begin nFails++; $display("FAIL addr_range got %b exp 1", ErrAddrRange); end
    nChecks++; if (ErrAppendValid !== 1'b0) begin nFails++; $display("FAIL append_not_yet got %b exp 0", ErrAppendValid); end
    doStore(BECMD_Append, 32'd3, 10'h2A, 10'h2A, 64'h50);
    readBlock(BECMD_Read, 32'd3, 10'h2A, 10'h2A, 4'hF);
    nChecks++; if (ErrAppendValid !== 1'b1) begin nFails++; $display("FAIL append_valid got %b exp 1", ErrAppendValid); end
    nChecks++; if (got[2] !== 64'h52) begin nFails++; $display("FAIL append_overwrite got %h exp 52", got[2]); end
    readBlock(BECMD_Read, 32'd0, 10'h0, 10'h0, 4'hF);
    nChecks++; if (got[5] !== 64'h45) begin nFails++; $display("FAIL oob_alias got %h exp 45", got[5]); end
    nChecks++; if (AccessCount !== 32'd15) begin nFails++; $display("FAIL count_total got %0d exp 15", AccessCount); end
  endtask

  task automatic test_back_to_back();
    doStore(BECMD_Update, 32'd12, 10'h0, 10'h5, 64'h60);
    readBlock(BECMD_Read, 32'd12, 10'h5, 10'h5, 4'hF);
    nChecks++; if (waitCyc !== 0) begin nFails++; $display("FAIL b2b_accept_wait got %0d exp 0", waitCyc); end
    for (int k = 0; k < 8; k++) begin
      nChecks++; if (got[k] !== 64'h60 + 64'(k)) begin nFails++; $display("FAIL b2b_chunk%0d got %h exp %h", k, got[k], 64'h60 + 64'(k)); end
    end
  endtask

  task automatic test_reset_mid_store();
    sendCmd(BECMD_Update, 32'd7, 10'h0, 10'h9);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      bus.CmdInValid = 1'b0;
      bus.StoreDataValid = 1'b1;
      bus.StoreData = 64'h70 + 64'(k);
      @(posedge Clock);
    end
    @(negedge Clock);
    bus.StoreDataValid = 1'b0;
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    nChecks++; if (bus.CmdInReady !== 1'b1) begin nFails++; $display("FAIL midreset_cmdready got %b exp 1", bus.CmdInReady); end
    nChecks++; if (bus.StoreDataReady !== 1'b0) begin nFails++; $display("FAIL midreset_storeready got %b exp 0", bus.StoreDataReady); end
    nChecks++; if ({ErrAddrRange, ErrLeafMismatch, ErrAppendValid} !== 3'b000) begin nFails++; $display("FAIL midreset_errs got %b exp 000", {ErrAddrRange, ErrLeafMismatch, ErrAppendValid}); end
    nChecks++; if (AccessCount !== 32'd0) begin nFails++; $display("FAIL midreset_count got %0d exp 0", AccessCount); end
    readBlock(BECMD_Read, 32'd7, 10'h9, 10'h9, 4'hF);
    for (int k = 0; k < 8; k++) begin
      nChecks++; if (got[k] !== 64'h0) begin nFails++; $display("FAIL midreset_chunk%0d got %h exp 0", k, got[k]); end
    end
    readBlock(BECMD_Read, 32'd3, 10'h0, 10'h0, 4'hF);
    nChecks++; if (got[0] !== 64'h0) begin nFails++; $display("FAIL midreset_valid_cleared got %h exp 0", got[0]); end
    nChecks++; if (ErrLeafMismatch !== 1'b0) begin nFails++; $display("FAIL midreset_no_leafchk got %b exp 0", ErrLeafMismatch); end
  endtask

  initial begin
    test_reset();
    test_store_read();
    test_unwritten();
    test_backpressure();
    test_leaf();
    test_errors();
    test_back_to_back();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/oram_flat_backend.md
Name: oram_flat_backend

Overview:
- Responder end of the frontend→backend ORAM interface: accepts commands, stores or returns one block per command as FEDWidth chunks.
- Does not run Path ORAM. It keeps a flat block store indexed by program address, plus a per-address leaf table used for consistency checks.
- Slots in place of the Path ORAM backend for frontend bring-up and co-simulation. It also serves as the golden data model for frontend verification.

Parameters:
- ORAMU, 32, address width.
- ORAML, 10, leaf width.
- ORAMB, 512, block size in bits.
- FEDWidth, 64, chunk width. BlkChunks = ORAMB/FEDWidth (8).
- NumBlocks, 1024, store depth in blocks; power of two.
- LeafCheck, 1, enables OldLeaf consistency checking.

Ports:
- Clock  in  1  clock.
- Reset  in  1  synchronous, active-low reset.
- CmdInReady  out  1  command accept.
- CmdInValid  in  1  command valid.
- CmdIn  in  2  backend command (BECMD_*).
- AddrIn  in  ORAMU  block address.
- OldLeafIn  in  ORAML  leaf the frontend believes the block maps to.
- NewLeafIn  in  ORAML  remapped leaf.
- StoreDataReady  out  1  write chunk accept.
- StoreDataValid  in  1  write chunk valid.
- StoreData  in  FEDWidth  write chunk.
- LoadDataReady  in  1  frontend accepts read chunk.
- LoadDataValid  out  1  read chunk valid.
- LoadData  out  FEDWidth  read chunk.
- ErrAddrRange  out  1  sticky: AddrIn >= NumBlocks seen.
- ErrLeafMismatch  out  1  sticky: OldLeafIn differed from stored leaf.
- ErrAppendValid  out  1  sticky: Append to an already-valid block.
- AccessCount  out  32  number of commands accepted.

Behaviour:
- Reset (Reset==0 at posedge):
  - State goes to IDLE.
  - All Err* = 0, AccessCount = 0, LoadDataValid = 0, StoreDataReady = 0.
  - All block valid bits clear. Data and leaf RAM contents are not cleared.
- Reset mid-transfer aborts the command. Any partially written block is left with its valid bit cleared.
- Commands:
  - BECMD_Update = 0: write block; no load data.
  - BECMD_Append = 1: write block; no load data.
  - BECMD_Read = 2: return block; block stays valid.
  - BECMD_ReadRmv = 3: return block; valid bit cleared after the last chunk is accepted.
- Every accepted command writes NewLeafIn into the leaf table at its address.
- CmdInReady = (state==IDLE). A command is accepted on CmdInReady && CmdInValid. AccessCount increments on acceptance and wraps.
- Index = AddrIn[log2(NumBlocks)-1:0]. If AddrIn >= NumBlocks, set ErrAddrRange and still process the command at Index.
- On acceptance with LeafCheck=1 and the block valid: if OldLeafIn != stored leaf, set ErrLeafMismatch (one cycle after accept).
- On acceptance of Append to a valid block: set ErrAppendValid. The write still proceeds.
- States:
  - IDLE →STORE on accept of Update/Append. IDLE →LOAD on accept of Read/ReadRmv.
  - STORE: StoreDataReady = 1. Chunk k is written on each StoreDataValid handshake, k counting 0..BlkChunks-1. After the last chunk the valid bit is set and the block goes →IDLE. Store data arriving while in IDLE is not accepted.
  - LOAD:
    - RAM is synchronous read with 1-cycle latency. Reads are issued whenever the 2-entry output FIFO will have space, so there are no bubbles.
    - The first LoadDataValid is 2 cycles after the accept edge. With LoadDataReady held high, one chunk is delivered per cycle.
    - The block goes →IDLE when the last chunk is accepted.
    - Load data for an invalid block is all zeros; the counter advances identically.
- Back-to-back: a new command may be accepted the cycle after the state returns to IDLE. A read immediately following a write to the same address returns the new data (the write completes before IDLE).
- LoadDataValid holds and LoadData is stable while LoadDataReady = 0.

Decomposition:
- Shared package: BECMD_* encodings, BECMDWidth = 2, backend state enum (IDLE, STORE, LOAD), BlkChunks derivation.
- Sub-module oram_flat_backend_outq: 2-entry FIFO with valid/ready and a registered output. It absorbs RAM read latency against LoadDataReady backpressure.
- The data RAM (NumBlocks*BlkChunks x FEDWidth) and the leaf RAM (NumBlocks x ORAML) are inferred inline.

Test Plan:
- Store then read back: Update addr 5, chunks 0x10..0x17 → Read addr 5 returns 0x10..0x17. First valid 2 cycles after accept; 8 consecutive cycles with ready high; AccessCount = 2.
- Read of an unwritten block: Read addr 9 after reset → 8 chunks of 0, no errors. ReadRmv addr 5 then Read addr 5 → the second read returns zeros.
- Backpressure: Read addr 5 with LoadDataReady toggling 1,0,0,1,… → no chunk lost or duplicated; data stable during stalls; CmdInReady = 0 until the 8th chunk is accepted.
- Leaf check: Append addr 3 NewLeaf 0x2A, then Read addr 3 OldLeaf 0x2A → no error. Read addr 3 OldLeaf 0x2B → ErrLeafMismatch = 1 and stays sticky.
- Error flags: AddrIn = 1024 → ErrAddrRange = 1. Append addr 3 twice → ErrAppendValid = 1.
- Reset mid-STORE: Reset low after 3 chunks of Update addr 7 → CmdInReady = 1 and all flags 0 after reset; Read addr 7 returns zeros.
